spi_slave: RTL and testbench

- Serial front end for the single-port RAM command interface.
- Shifts 10-bit command frames in from MOSI under SS_n and presents each frame as rx_data with a one-cycle rx_valid pulse.
- For read-data frames, captures the RAM's tx_data/tx_valid reply and serializes it MSB-first on MISO.
- Sits between the SPI pins and the RAM; the system clock is the SPI bit clock, one bit per clk.

---
 rtl/spi_slave_if.sv | 21 ++
 rtl/spi_slave.sv | 109 ++++++++++
 tb/tb_spi_slave.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI pin and RAM-side signal bundle for the spi_slave front end.
// The master modport is the pins/RAM side; the slave modport is the front end.
interface spi_slave_if;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave front end: 10-bit command frames in on MOSI,
// 8-bit RAM read replies out on MISO, one bit per clk.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    spi_slave_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] bit_cnt;
    logic [8:0] shreg;
    logic       frame_done;
    logic       rd_addr_done;
    logic       reply_busy;
    logic       reply_used;
    logic [2:0] reply_cnt;
    logic [7:0] tx_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.SS_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)          state_d = IDLE;
                else if (!bus.MOSI)    state_d = WRITE;
                else if (rd_addr_done) state_d = READ_DATA;
                else                   state_d = READ_ADD;
            end
            default: begin
                if (bus.SS_n) state_d = IDLE;
            end
        endcase
    end

    // SS_n is checked before the data bit, so a rise on the last bit drops the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= 4'd0;
            shreg        <= 9'd0;
            frame_done   <= 1'b0;
            rd_addr_done <= 1'b0;
            reply_busy   <= 1'b0;
            reply_used   <= 1'b0;
            reply_cnt    <= 3'd0;
            tx_sh        <= 8'd0;
            bus.MISO     <= 1'b0;
            bus.rx_data  <= 10'd0;
            bus.rx_valid <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (bus.SS_n || state_q == IDLE) begin
                bit_cnt    <= 4'd0;
                shreg      <= 9'd0;
                frame_done <= 1'b0;
                reply_busy <= 1'b0;
                reply_used <= 1'b0;
                reply_cnt  <= 3'd0;
                tx_sh      <= 8'd0;
                bus.MISO   <= 1'b0;
            end else if (state_q == CHK_CMD) begin
                shreg <= {8'd0, bus.MOSI};
            end else if (!frame_done) begin
                shreg   <= {shreg[7:0], bus.MOSI};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd8) begin
                    bus.rx_data  <= {shreg, bus.MOSI};
                    bus.rx_valid <= 1'b1;
                    frame_done   <= 1'b1;
                    if (state_q == READ_ADD)
                        rd_addr_done <= 1'b1;
                    else if (state_q == READ_DATA)
                        rd_addr_done <= 1'b0;
                end
            end else if (state_q == READ_DATA) begin
                if (reply_busy) begin
                    if (reply_cnt != 3'd0) begin
                        bus.MISO  <= tx_sh[7];
                        tx_sh     <= {tx_sh[6:0], 1'b0};
                        reply_cnt <= reply_cnt - 3'd1;
                    end else begin
                        bus.MISO   <= 1'b0;
                        reply_busy <= 1'b0;
                    end
                end else if (!reply_used && bus.tx_valid) begin
                    tx_sh      <= {bus.tx_data[6:0], 1'b0};
                    bus.MISO   <= bus.tx_data[7];
                    reply_cnt  <= 3'd7;
                    reply_busy <= 1'b1;
                    reply_used <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of command frames with
// expected rx_data and MISO replies, plus abort and reset sequences.
module tb_spi_slave;
    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   pulses;
    int   miso_hi;

    spi_slave_if bus ();

    spi_slave dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] pl;
        logic [9:0] rx;
        logic [7:0] tx;
        logic       reply;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.rx_valid) pulses++;
        if (bus.MISO) miso_hi++;
    endtask

    task automatic send_frame(input logic [9:0] f);
        pulses  = 0;
        miso_hi = 0;
        tick();
        bus.SS_n = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            tick();
            bus.MOSI = f[i];
        end
        tick();
    endtask

    task automatic close_frame();
        tick();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        logic [8:0]  got;
        logic [31:0] exp;
        send_frame({v.cmd, v.pl});
        check("rx_pulse", pulses, 1);
        check("rx_data", 32'(bus.rx_data), 32'(v.rx));
        check("miso_quiet", miso_hi, 0);
        tick();
        bus.tx_valid = 1'b1;
        bus.tx_data  = v.tx;
        got = 9'd0;
        for (int k = 0; k < 9; k++) begin
            tick();
            bus.tx_valid = 1'b0;
            bus.MOSI     = k[0];
            got = {got[7:0], bus.MISO};
        end
        exp = v.reply ? 32'({v.tx, 1'b0}) : 32'd0;
        check("reply", 32'(got), exp);
        check("one_frame", pulses, 1);
        close_frame();
    endtask

    initial begin
        logic [2:0] got3;
        vec_t       v;
        total        = 0;
        passed       = 0;
        pulses       = 0;
        miso_hi      = 0;
        rst_n        = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = 8'd0;
        bus.tx_valid = 1'b0;

        vecs[0] = '{2'b00, 8'h3C, 10'h03C, 8'h5A, 1'b0};
        vecs[1] = '{2'b01, 8'hA5, 10'h1A5, 8'h5A, 1'b0};
        vecs[2] = '{2'b10, 8'h3C, 10'h23C, 8'hFF, 1'b0};
        vecs[3] = '{2'b11, 8'h00, 10'h300, 8'hA5, 1'b1};
        vecs[4] = '{2'b11, 8'h00, 10'h300, 8'hFF, 1'b0};
        vecs[5] = '{2'b11, 8'h00, 10'h300, 8'h96, 1'b1};
        vecs[6] = '{2'b10, 8'h01, 10'h201, 8'h77, 1'b0};
        vecs[7] = '{2'b01, 8'hFF, 10'h1FF, 8'h33, 1'b0};
        vecs[8] = '{2'b10, 8'h00, 10'h200, 8'h81, 1'b1};

        #1;
        check("rst_miso", 32'(bus.MISO), 0);
        check("rst_rx_valid", 32'(bus.rx_valid), 0);
        check("rst_rx_data", 32'(bus.rx_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (i == 2) begin
                // abort after 6 frame bits
                pulses = 0;
                tick();
                bus.SS_n = 1'b0;
                for (int b = 9; b > 3; b--) begin
                    tick();
                    bus.MOSI = b[0];
                end
                tick();
                bus.SS_n = 1'b1;
                tick();
                tick();
                check("abort6_pulse", pulses, 0);
                check("abort6_rx", 32'(bus.rx_data), 32'h1A5);
            end
            if (i == 3) begin
                // SS_n rises on the edge sampling bit 0
                pulses = 0;
                tick();
                bus.SS_n = 1'b0;
                for (int b = 9; b > 0; b--) begin
                    tick();
                    bus.MOSI = (b >= 8);
                end
                tick();
                bus.MOSI = 1'b1;
                bus.SS_n = 1'b1;
                tick();
                tick();
                check("abort_b0_pulse", pulses, 0);
                check("abort_b0_rx", 32'(bus.rx_data), 32'h23C);
            end
            run_vec(vecs[i]);
        end

        v = '{2'b10, 8'h12, 10'h212, 8'h00, 1'b0};
        run_vec(v);
        send_frame(10'h355);
        check("rabort_rx", 32'(bus.rx_data), 32'h355);
        tick();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA5;
        tick();
        bus.tx_valid = 1'b0;
        got3[2] = bus.MISO;
        tick();
        got3[1] = bus.MISO;
        tick();
        got3[0] = bus.MISO;
        bus.SS_n = 1'b1;
        tick();
        check("rabort_bits", 32'(got3), 32'h5);
        check("rabort_miso0", 32'(bus.MISO), 0);
        tick();
        v = '{2'b11, 8'h00, 10'h300, 8'hC3, 1'b0};
        run_vec(v);

        send_frame(10'h3AB);
        tick();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        tick();
        bus.tx_valid = 1'b0;
        check("pre_rst_miso", 32'(bus.MISO), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(bus.MISO), 0);
        check("mid_rst_rx", 32'(bus.rx_data), 0);
        bus.SS_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        v = '{2'b10, 8'h44, 10'h244, 8'h00, 1'b0};
        run_vec(v);
        send_frame(10'h0C3);
        check("pre_rst_valid", 32'(bus.rx_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_valid", 32'(bus.rx_valid), 0);
        check("rst2_rx", 32'(bus.rx_data), 0);
        check("rst2_miso", 32'(bus.MISO), 0);
        bus.SS_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        v = '{2'b11, 8'h00, 10'h300, 8'h5A, 1'b0};
        run_vec(v);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
